ccff_bitstream_loader: RTL
==========================

// Module: ccff_bitstream_loader
// PURPOSE
//  Upstream driver of the configuration-chain head for routing/connection blocks.
//  Accepts bitstream words over a valid/ready stream and serializes them LSB-first onto ccff_head.
//  Emits one chain-clock enable per bit.
//  Optional verify pass re-shifts the same stream and compares against ccff_tail, restoring contents.
// PARAMETERS
//  WORD_W     8     bitstream word width (>=1)
//  CHAIN_LEN  1024  number of config flip-flops between ccff_head and ccff_tail (>=1)
//  CNT_W      16    width of mismatch counter (saturating)
// PORTS
//  prog_clk      in   1        single clock; all state on rising edge
//  pReset        in   1        asynchronous, active-high reset
//  start         in   1        pulse: begin a pass (sampled in IDLE only)
//  verify        in   1        sampled with start: 0=load pass, 1=verify pass
//  bs_data       in   WORD_W   bitstream word, bit 0 shifted first
//  bs_valid      in   1        bs_data valid
//  bs_ready      out  1        word accepted when bs_valid & bs_ready
//  ccff_head     out  1        serial bit to chain head
//  ccff_shift_en out  1        chain clock enable; chain captures ccff_head on edges where =1
//  ccff_tail     in   1        chain tail bit (output of last config FF)
//  busy          out  1        pass in progress
//  done          out  1        one-cycle pulse at end of pass
//  err           out  1        sticky: verify pass saw >=1 mismatch; cleared by next accepted start
//  mismatch_cnt  out  CNT_W    mismatches in last verify pass, saturates at 2^CNT_W-1
// BEHAVIOUR
//  Reset (async, pReset=1): state=IDLE; bs_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0,
//   err=0, mismatch_cnt=0; bit counters=0. Chain contents are undefined after mid-pass reset.
//  FSM states: IDLE, WAIT, SHIFT, FIN.
//   IDLE: start=1 -> WAIT; latch verify into mode.
//    - if mode=1, clear mismatch_cnt and err.
//    - if mode=0, err/mismatch_cnt keep their values.
//    - In all cases, remaining = CHAIN_LEN.
//   WAIT: bs_ready=1. On bs_valid -> load shift register with bs_data.
//    - nbits = min(WORD_W, remaining).
//    - Go to SHIFT.
//   SHIFT: each cycle: ccff_head = sreg[0], ccff_shift_en=1, sreg >>= 1, remaining--.
//    - After nbits cycles: remaining==0 -> FIN, else -> WAIT.
//    - Upper WORD_W-nbits bits of the last word are discarded.
//   FIN: done=1 for exactly one cycle, busy drops same cycle -> IDLE.
//  busy=1 in WAIT/SHIFT/FIN. start while busy is ignored.
//  Latency:
//   - Word accepted at edge t -> its bit 0 on ccff_head with shift_en in cycle t+1.
//   - bs_ready is 0 throughout SHIFT, so there is no back-to-back word acceptance.
//   - Total pass = ceil(CHAIN_LEN/WORD_W) words, exactly CHAIN_LEN shift_en cycles.
//  ccff_head/ccff_shift_en are registered outputs; ccff_head holds last value when shift_en=0.
//  Verify (mode=1):
//   - In every cycle with ccff_shift_en=1, compare ccff_tail (pre-edge value) with ccff_head.
//   - On inequality, increment mismatch_cnt (saturating) and set err.
//   - Bit i emerging during verify is bit i shifted during the prior load, so contents are restored.
//  bs_valid low in WAIT: remain in WAIT indefinitely; no shift_en emitted.
//  CHAIN_LEN < WORD_W: single word, CHAIN_LEN shifts.
// TESTING
//  1. WORD_W=8, CHAIN_LEN=6, load, word 8'hA5
//     -> bs_ready once; 6 shift_en cycles with head=1,0,1,0,0,1; done pulse; err=0.
//  2. CHAIN_LEN=20, model chain, load words 8'h3C,8'hF0,8'h0F, then verify with same words
//     -> mismatch_cnt=0, err=0, model chain unchanged.
//  3. Same as 2 but verify word 2 = 8'hF1
//     -> mismatch_cnt=1, err=1 after done; next load start leaves err=1; next verify start clears it.
//  4. bs_valid withheld 5 cycles in WAIT
//     -> no shift_en, busy stays 1; then word accepted, head bit 0 next cycle.
//  5. pReset asserted mid-SHIFT (bit 3 of word 2)
//     -> all outputs 0 asynchronously; IDLE; new start runs a full CHAIN_LEN-shift pass.
//  6. verify with mismatch on every bit, CNT_W=2, CHAIN_LEN=6 -> mismatch_cnt saturates at 3.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Serializes a valid/ready bitstream LSB-first onto a configuration chain head.
// A verify pass re-shifts the same stream and checks it against the chain tail.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [1:0]        dbg_state
);

  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int NW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_mode;
  logic [WORD_W-1:0] r_sreg;
  logic [RW-1:0]     r_remaining;
  logic [NW-1:0]     r_left;
  logic              r_ready;
  logic              r_head;
  logic              r_shift_en;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [NW-1:0]     w_left_init;

  // Bits still to emit after the first one of a word: min(WORD_W, remaining) - 1.
  always_comb begin
    w_left_init = NW'(WORD_W - 1);
    if (32'(r_remaining) < WORD_W)
      w_left_init = NW'(r_remaining - 1'b1);
  end

  // Stream handshake: a word transfers on a rising edge where bs_valid and bs_ready are both 1.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_sreg      <= '0;
      r_remaining <= '0;
      r_left      <= '0;
      r_ready     <= 1'b0;
      r_head      <= 1'b0;
      r_shift_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode      <= verify;
            r_remaining <= RW'(CHAIN_LEN);
            r_ready     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_WAIT;
            if (verify) begin
              r_err <= 1'b0;
              r_cnt <= '0;
            end
          end
        end
        S_WAIT: begin
          if (bs_valid) begin
            r_ready     <= 1'b0;
            r_head      <= bs_data[0];
            r_shift_en  <= 1'b1;
            r_sreg      <= bs_data >> 1;
            r_remaining <= r_remaining - 1'b1;
            r_left      <= w_left_init;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_left != '0) begin
            r_head      <= r_sreg[0];
            r_sreg      <= r_sreg >> 1;
            r_remaining <= r_remaining - 1'b1;
            r_left      <= r_left - 1'b1;
          end else begin
            r_shift_en <= 1'b0;
            if (r_remaining == '0) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_ready <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Tail is the pre-edge value of the last FF, aligned with the bit now on the head.
      if (r_mode && r_shift_en && (ccff_tail != r_head)) begin
        r_err <= 1'b1;
        if (r_cnt != {CNT_W{1'b1}})
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bs_ready      = r_ready;
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign mismatch_cnt  = r_cnt;
  assign dbg_state     = r_state;

endmodule
